// File: rtl/gf256_pkg.sv
// gf256_pkg: shared constants and state encoding for the GF(2^8) sequential multiplier
package gf256_pkg;
  localparam logic [7:0] POLY_LOW = 8'h1B;
  localparam int ITER = 8;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/xfx_mult.sv
// xfx_mult: multiply a GF(2^8) element by x, reducing modulo 0x11B
module xfx_mult
  import gf256_pkg::*;
(
  input  logic [7:0] f,
  output logic [7:0] v
);
  assign v = {f[6:0], 1'b0} ^ (POLY_LOW & {8{f[7]}});
endmodule

// File: rtl/gf256_mul_seq.sv
// gf256_mul_seq: constant-time shift-and-add GF(2^8) multiplier, one product per 8 RUN cycles
module gf256_mul_seq
  import gf256_pkg::*;
#(
  parameter bit CLR_ON_ACCEPT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] p,
  output logic       busy
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [7:0] acc, t, bsh, t_x, acc_nx;
  xfx_mult u_xfx (.f(t), .v(t_x));
  assign acc_nx = acc ^ (t & {8{bsh[0]}});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      t         <= '0;
      bsh       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            t        <= a;
            bsh      <= b;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (CLR_ON_ACCEPT) p <= '0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          t   <= t_x;
          bsh <= bsh >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) begin
            p         <= acc_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf256_mul_seq.sv
// tb_gf256_mul_seq: scoreboard bench for gf256_mul_seq against a polynomial-division reference model
module tb_gf256_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [7:0] p;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {logic [7:0] p; int c;} exp_t;
  exp_t q[$];
  logic prev_v = 1'b0;
  logic [7:0] held_p;

  gf256_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r = '0;
    for (int i = 0; i < 8; i++) if (y[i]) r ^= 16'(x) << i;
    for (int i = 14; i >= 8; i--) if (r[i]) r ^= 16'h11B << (i - 8);
    return r[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // scoreboard: push on accept, pop on output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) q.push_back('{gmul(a, b), cyc + 1});
      if (out_valid) begin
        if (!prev_v) begin
          held_p = p;
          if (q.size() == 0) timeout("unexpected_output");
          else chk("latency", cyc - q[0].c, 8);
        end else chk("p_stable", p, held_p);
        chk("in_ready_low_done", in_ready, 0);
        chk("busy_done", busy, 1);
      end
      if (out_valid && out_ready && q.size() != 0) chk("product", p, q.pop_front().p);
      prev_v = out_valid;
    end
  end

  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp,
                     input int stall, input bit tog);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin timeout("in_ready"); return; end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("p_cleared_on_accept", p, 0);
    chk("busy_run", busy, 1);
    out_ready = (stall == 0);
    n = 0;
    while (!out_valid && n < 20) begin
      if (tog) begin a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom); end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin timeout("out_valid"); out_ready = 1'b1; return; end
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; chk("stall_in_ready", in_ready, 0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("p_kept_idle", p, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);
    run(8'h57, 8'h83, 8'hC1, 0, 0);
    run(8'h53, 8'hCA, 8'h01, 0, 0);
    run(8'h57, 8'h13, 8'hFE, 0, 0);
    run(8'h01, 8'hAE, 8'hAE, 0, 0);
    run(8'h00, 8'hFF, 8'h00, 0, 0);
    run(8'hFF, 8'h00, 8'h00, 0, 0);
    run(8'h57, 8'h83, 8'hC1, 5, 0);
    run(8'h57, 8'h83, 8'hC1, 0, 1);
    // abort mid-RUN: reset on the edge where cnt=4
    a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_p", p, 0);
    chk("abort_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready_next", in_ready, 1);
    run(8'h02, 8'h87, 8'h15, 0, 0);
    for (int k = 0; k < 30; k++) begin
      logic [7:0] x, y;
      x = 8'($urandom); y = 8'($urandom);
      run(x, y, gmul(x, y), int'($urandom_range(0, 3)), 1'($urandom));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gf256_mul_seq.md
GF256_MUL_SEQ -- requirements
Module: gf256_mul_seq

Interface
REQ-001 SHALL have parameter CLR_ON_ACCEPT, default 1; when 1, p is zeroed on the cycle an operand pair is accepted.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b present.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  8  multiplicand, GF(2^8) polynomial basis.
REQ-007 SHALL have port b  input  8  multiplier, GF(2^8) polynomial basis.
REQ-008 SHALL have port out_valid  output  1  p holds a finished product.
REQ-009 SHALL have port out_ready  input  1  consumer takes p.
REQ-010 SHALL have port p  output  8  product a*b mod x^8+x^4+x^3+x+1 (0x11B).
REQ-011 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-014 SHALL on transfer: latch t<=a and bsh<=b, set acc<=0 and cnt<=0, enter RUN, and zero p if CLR_ON_ACCEPT=1.
REQ-015 SHALL, per RUN edge: acc<=acc ^ (t & {8{bsh[0]}}); t<=xtime(t); bsh<=bsh>>1; cnt<=cnt+1.
REQ-016 SHALL produce xtime(t) exclusively from one xfx_mult instance (f=t, v=xtime(t)).
REQ-017 SHALL execute exactly 8 RUN cycles regardless of operand values: no early exit on b=0 or a=0, and no data-dependent branching.
REQ-018 SHALL on the 8th RUN edge (cnt=7) load p<=final acc, enter DONE and assert out_valid; latency is 8 edges from the accept edge to out_valid high.
REQ-019 SHALL hold p and out_valid stable in DONE until the edge where out_ready=1, then return to IDLE with out_valid=0.
REQ-020 SHALL raise in_ready on the cycle after the out handshake; throughput is one product per 10 cycles minimum.
REQ-021 SHALL ignore in_valid, a and b outside IDLE; operand changes during RUN do not alter the result.
REQ-022 SHALL keep p unchanged in IDLE after a handshake (last product visible, out_valid=0).
REQ-023 SHALL use a 3-bit cnt that wraps 7->0 only on the RUN->DONE transition.

Reset
REQ-024 SHALL, on a rising edge with rst_n=0, force state=IDLE, cnt=0, acc=0, t=0, bsh=0, p=0, out_valid=0 and busy=0; in_ready reads 1 from the first edge with rst_n=1.
REQ-025 SHALL abandon any in-flight operation on reset with no partial result emitted; the first accept after reset behaves as from power-up.
REQ-026 SHALL give reset priority over every handshake on the same edge.

Structure
REQ-027 SHALL take POLY_LOW=8'h1B, ITER=8, CNT_W=3 and state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from shared package gf256_pkg.
REQ-028 SHALL contain exactly one sub-module, the existing xfx_mult; no other GF logic is duplicated inline.

Verification
REQ-029 SHALL cover a=0x57, b=0x83 -> p=0xC1 with out_valid high exactly 8 edges after the accept edge.
REQ-030 SHALL cover a=0x53, b=0xCA -> p=0x01; a=0x57, b=0x13 -> p=0xFE; a=0x01, b=0xAE -> p=0xAE.
REQ-031 SHALL cover a=0x00, b=0xFF and a=0xFF, b=0x00 -> p=0x00, each with latency exactly 8 (constant time).
REQ-032 SHALL cover out_ready held low 5 cycles after out_valid -> p stable, in_ready=0 throughout, in_ready=1 the cycle after out_ready=1.
REQ-033 SHALL cover rst_n=0 for one edge at RUN cnt=4 -> all outputs 0, in_ready=1 next; then a=0x02, b=0x87 -> p=0x15.
REQ-034 SHALL cover a and b toggled randomly during RUN after accepting 0x57/0x83 -> p=0xC1 still.
